// File: rtl/axi_mem_arbiter.sv
// Two-client (IFU read-only, LSU read/write) round-robin arbiter driving one AXI4 master port.
// One single-beat transaction in flight; responses return as one-cycle pulses to the owner.
module axi_mem_arbiter #(
  parameter logic [3:0] IFU_ID = 4'd0,
  parameter logic [3:0] LSU_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_we,
  input  logic [31:0] lsu_addr,
  input  logic [2:0]  lsu_size,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_resp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  input  logic        rlast,
  input  logic [3:0]  rid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  output logic [3:0]  awid,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  output logic        wlast,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  input  logic [3:0]  bid,
  output logic        bready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  logic [2:0]  state;
  logic        pri_lsu;
  logic        own_lsu;
  logic        aw_done;
  logic        w_done;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  size_q;
  logic        grant_lsu;
  logic        grant_ifu;
  logic        aw_hs;
  logic        w_hs;
  logic        unused_ids;

  assign unused_ids = ^{rid, bid};

  // pri_lsu set means LSU wins a tie; it flips to the loser after every grant.
  always_comb begin
    grant_lsu = lsu_req_valid && (!ifu_req_valid || pri_lsu);
    grant_ifu = ifu_req_valid && !grant_lsu;
  end

  assign ifu_req_ready = (state == S_IDLE) && grant_ifu;
  assign lsu_req_ready = (state == S_IDLE) && grant_lsu;

  assign araddr  = addr_q;
  assign arid    = own_lsu ? LSU_ID : IFU_ID;
  assign arlen   = '0;
  assign arsize  = size_q;
  assign arburst = 2'b01;
  assign arvalid = (state == S_AR);
  assign rready  = (state == S_R);

  assign awaddr  = addr_q;
  assign awid    = LSU_ID;
  assign awlen   = '0;
  assign awsize  = size_q;
  assign awburst = 2'b01;
  assign awvalid = (state == S_AW) && !aw_done;
  assign wvalid  = (state == S_AW) && !w_done;
  assign wlast   = wvalid;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign bready  = (state == S_B);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  assign ifu_resp_valid = (state == S_RESP) && !own_lsu;
  assign lsu_resp_valid = (state == S_RESP) && own_lsu;
  assign ifu_rdata      = rdata_q;
  assign lsu_rdata      = rdata_q;
  assign ifu_resp_err   = err_q;
  assign lsu_resp_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pri_lsu <= 1'b1;
      own_lsu <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_lsu || grant_ifu) begin
            own_lsu <= grant_lsu;
            pri_lsu <= !grant_lsu;
            addr_q  <= grant_lsu ? lsu_addr : ifu_addr;
            size_q  <= grant_lsu ? lsu_size : 3'b010;
            wdata_q <= grant_lsu ? lsu_wdata : '0;
            wstrb_q <= grant_lsu ? lsu_wstrb : '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= (grant_lsu && lsu_we) ? S_AW : S_AR;
          end
        end
        S_AR: if (arready) state <= S_R;
        S_R: begin
          if (rvalid) begin
            rdata_q <= rdata;
            err_q   <= (rresp != 2'b00) || !rlast;
            state   <= S_RESP;
          end
        end
        S_AW: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          // Handshakes may land in the same cycle or on different cycles.
          if ((aw_done || aw_hs) && (w_done || w_hs)) state <= S_B;
        end
        S_B: begin
          if (bvalid) begin
            err_q <= (bresp != 2'b00);
            state <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter with a small single-beat AXI4 memory/UART slave model.
module tb_axi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [2:0]  lsu_size;
  logic [3:0]  lsu_wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;
  logic [3:0]  arid, rid, awid, bid, wstrb;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  axi_mem_arbiter #(.IFU_ID(4'd0), .LSU_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
    .lsu_addr(lsu_addr), .lsu_size(lsu_size), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .araddr(araddr), .arvalid(arvalid), .arid(arid), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rid(rid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awid(awid), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bid(bid), .bready(bready)
  );

  // Slave model: ready one cycle after valid, response one cycle after handshake.
  logic [31:0] ram [16];
  logic [7:0]  uart_byte;

  assign rdata = (araddr == 32'h3000_0000) ? 32'h8000_02b7 :
                 (araddr == 32'h3000_0004) ? 32'h0002_8067 : ram[araddr[5:2]];
  assign rresp = 2'b00;
  assign rlast = 1'b1;
  assign rid   = arid;
  assign bresp = 2'b00;
  assign bid   = awid;

  always @(posedge clk) begin
    if (rst) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      arready <= arvalid && !arready;
      if (arvalid && arready) rvalid <= 1'b1;
      else if (rvalid && rready) rvalid <= 1'b0;
      awready <= awvalid && !awready;
      wready  <= wvalid && !wready;
      if (awvalid && awready && wvalid && wready) begin
        bvalid <= 1'b1;
        if (awaddr == 32'ha000_03f8) begin
          uart_byte <= wdata[7:0];
          $display("uart: %c", wdata[7:0]);
        end else if (awaddr[31:28] == 4'h8) begin
          for (int b = 0; b < 4; b++)
            if (wstrb[b]) ram[awaddr[5:2]][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Protocol monitor, sampled shortly after the falling edge.
  logic        hold_v = 1'b0;
  logic [31:0] hold_addr;
  logic        outst = 1'b0;
  logic        prev_resp = 1'b0;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      hold_v    = 1'b0;
      outst     = 1'b0;
      prev_resp = 1'b0;
    end else begin
      if (hold_v) check("araddr_stable", araddr, hold_addr);
      else if (arvalid) begin
        hold_v    = 1'b1;
        hold_addr = araddr;
      end
      if (rvalid && rready) hold_v = 1'b0;
      if ((arvalid && arready) || (awvalid && awready)) begin
        check("one_outstanding", {31'd0, outst}, 32'd0);
        outst = 1'b1;
      end
      if (prev_resp) check("resp_one_cycle", {31'd0, ifu_resp_valid || lsu_resp_valid}, 32'd0);
      prev_resp = ifu_resp_valid || lsu_resp_valid;
      if (ifu_resp_valid || lsu_resp_valid) outst = 1'b0;
    end
  end

  // Called at the falling edge of the cycle after acceptance; returns at the idle cycle after the pulse.
  task automatic follow(input bit is_lsu, input bit we, input logic [31:0] exp_rdata,
                        input logic [31:0] prev);
    int k;
    k = 1;
    while (k < 20) begin
      if (k == 1 || k == 2) begin
        if (we) check("aw_w_valid", {awvalid, wvalid, wlast, arvalid}, 4'b1110);
        else    check("ar_valid", {arvalid, awvalid, wvalid}, 3'b100);
      end
      if (k == 1) begin
        if (we) begin
          check("awid", awid, 4'd1);
          check("aw_fields", {awlen, awsize, awburst}, {8'd0, 3'b010, 2'b01});
        end else begin
          check("arid", arid, is_lsu ? 4'd1 : 4'd0);
          check("ar_fields", {arlen, arsize, arburst}, {8'd0, 3'b010, 2'b01});
        end
      end
      if (k == 3) begin
        if (we) check("b_phase", {awvalid, wvalid, bready}, 3'b001);
        else    check("r_phase", {arvalid, rready}, 2'b01);
      end
      if (is_lsu ? lsu_resp_valid : ifu_resp_valid) break;
      @(negedge clk);
      k++;
    end
    check("latency", k, 4);
    check("other_resp", is_lsu ? ifu_resp_valid : lsu_resp_valid, 0);
    check("no_accept_in_resp", {ifu_req_ready, lsu_req_ready}, 2'b00);
    if (we) check("wr_rdata_kept", lsu_rdata, prev);
    else    check("rdata", is_lsu ? lsu_rdata : ifu_rdata, exp_rdata);
    check("err", is_lsu ? lsu_resp_err : ifu_resp_err, 0);
    @(negedge clk);
    check("pulse_end", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
  endtask

  task automatic xact(input bit is_lsu, input bit we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] strb, input logic [31:0] exp_rdata);
    int k;
    logic [31:0] prev;
    @(negedge clk);
    prev = lsu_rdata;
    if (is_lsu) begin
      lsu_req_valid = 1'b1; lsu_we = we; lsu_addr = addr;
      lsu_size = 3'b010; lsu_wdata = wd; lsu_wstrb = strb;
    end else begin
      ifu_req_valid = 1'b1; ifu_addr = addr;
    end
    #1;
    k = 0;
    while (!(is_lsu ? lsu_req_ready : ifu_req_ready) && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("accept", is_lsu ? lsu_req_ready : ifu_req_ready, 1);
    @(negedge clk);
    lsu_req_valid = 1'b0;
    ifu_req_valid = 1'b0;
    follow(is_lsu, we, exp_rdata, prev);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_size = '0;
    lsu_wdata = '0; lsu_wstrb = '0;
    repeat (3) @(negedge clk);
    check("rst_valids", {arvalid, rready, awvalid, wvalid, bready, ifu_resp_valid,
                         lsu_resp_valid, ifu_req_ready, lsu_req_ready}, 9'd0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_wstrb", wstrb, 4'd0);
    rst = 1'b0;

    xact(1'b0, 1'b0, 32'h3000_0000, 32'd0, 4'd0, 32'h8000_02b7);

    xact(1'b1, 1'b1, 32'h8000_0010, 32'hdead_beef, 4'hf, 32'd0);
    xact(1'b1, 1'b0, 32'h8000_0010, 32'd0, 4'd0, 32'hdead_beef);
    xact(1'b1, 1'b1, 32'h8000_0010, 32'h0000_aa00, 4'h2, 32'd0);
    xact(1'b1, 1'b0, 32'h8000_0010, 32'd0, 4'd0, 32'hdead_aaef);

    xact(1'b1, 1'b1, 32'ha000_03f8, 32'h0000_0041, 4'h1, 32'd0);
    check("uart_byte", uart_byte, 8'h41);

    // Reset while the read waits in R: no pulse, ports quiet, next read normal.
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h3000_0000;
    #1;
    check("rst_test_accept", ifu_req_ready, 1);
    @(negedge clk);
    ifu_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("in_r_state", {arvalid, rready}, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("after_rst", {arvalid, rready, ifu_resp_valid, lsu_resp_valid}, 4'd0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (ifu_resp_valid || lsu_resp_valid) pulses++;
    end
    check("no_pulse_after_rst", pulses, 0);
    xact(1'b0, 1'b0, 32'h3000_0000, 32'd0, 4'd0, 32'h8000_02b7);

    // Round-robin: first tie to LSU, then with both still requesting, IFU.
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h3000_0004;
    lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h8000_0010; lsu_size = 3'b010;
    #1;
    check("tie1_grant", {lsu_req_ready, ifu_req_ready}, 2'b10);
    @(negedge clk);
    lsu_req_valid = 1'b0;
    follow(1'b1, 1'b0, 32'hdead_aaef, 32'd0);
    lsu_req_valid = 1'b1;
    #1;
    check("tie2_grant", {lsu_req_ready, ifu_req_ready}, 2'b01);
    @(negedge clk);
    ifu_req_valid = 1'b0;
    follow(1'b0, 1'b0, 32'h0002_8067, 32'd0);
    #1;
    check("tie2_lsu_next", lsu_req_ready, 1);
    @(negedge clk);
    lsu_req_valid = 1'b0;
    follow(1'b1, 1'b0, 32'hdead_aaef, 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
